aoc_input_sequencer: RTL and testbench
======================================

# aoc_input_sequencer

Streams a puzzle input held in a byte-addressed memory into a character-stream solver core over a valid/ready byte interface. It cleans the stream (drops CR and blank lines, appends a missing final newline), waits for the solver pipeline to drain and latches the solver's running result. It also reports line count and ragged-line errors. It sits between the input ROM/RAM and any `sol`-style solver, and is the single sequencer for a run.

## Interface
- `ADDR_W`, 15: memory address width; max input length 2^ADDR_W-1 bytes.
- `DRAIN_CYCLES`, 2: idle cycles after the final accepted byte before `sol_result` is captured; legal range 1..15.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle run request; sampled only in IDLE or DONE.
- `input_len` in ADDR_W: bytes to stream; sampled on accepted `start`.
- `mem_rd` out 1: memory read strobe.
- `mem_addr` out ADDR_W: read address.
- `mem_data` in 8: read data, valid the cycle after `mem_rd`.
- `sol_valid` out 1: byte offered to solver.
- `sol_char` out 8: byte value.
- `sol_ready` in 1: solver accepts when `sol_valid & sol_ready`.
- `sol_result` in 64: solver running result.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE.
- `result` out 64: captured `sol_result`.
- `line_count` out 16: newlines forwarded, including a padded one; saturates at 0xFFFF.
- `err` out 1: sticky ragged-line flag.

## Operation
- States: IDLE, FETCH, LOAD, SEND, PAD_NL, DRAIN, DONE.
- IDLE/DONE + `start`:
  - Clear `addr`, `line_count`, `err`, `result`, width registers and the "at line start" flag (set to 1).
  - Go to FETCH, or to DRAIN if `input_len`==0.
- FETCH: `mem_rd`=1, `mem_addr`=addr; next state LOAD.
- LOAD: capture `mem_data` into `char_q`; addr+1.
  - Skip the byte if `mem_data` is 0x0D, or if it is 0x0A while at line start.
  - For a skipped byte, go to FETCH if more bytes remain, else to the end check.
  - Otherwise go to SEND.
- SEND:
  - `sol_valid`=1, `sol_char`=`char_q`, held stable until accepted.
  - On accept, update line tracking.
  - Then go to FETCH if addr<`input_len`, else to the end check.
- End check:
  - If the last forwarded byte was not 0x0A and at least one byte was forwarded, go to PAD_NL.
  - Otherwise go to DRAIN.
- PAD_NL: offer 0x0A with the same hold-until-accept rule, then go to DRAIN.
- DRAIN:
  - Count DRAIN_CYCLES cycles.
  - In the last cycle, `result`<=`sol_result`; go to DONE.
- DONE: `done`=1. `result`, `line_count` and `err` hold until the next `start`.
- Line tracking on each accepted byte:
  - Non-newline: `cur_w`+1, clear line start.
  - Newline: `line_count`+1, compare `cur_w`, set line start, `cur_w`=0.
- `start` while busy is ignored.

## Timing
- Reset values: all outputs 0, including `mem_addr`, `sol_char`, `result` and `line_count`; state IDLE.
- Per forwarded byte, minimum 3 cycles with `sol_ready`=1: FETCH, LOAD, SEND.
- A skipped byte costs 2 cycles.
- `sol_valid` never drops without acceptance. `sol_char` is stable while `sol_valid & !sol_ready`.
- `busy` rises the cycle after an accepted `start`.
- `done` rises DRAIN_CYCLES cycles after the final acceptance, or after entering DRAIN for an empty input.
- Memory read latency is exactly 1; a 0-latency memory is not supported.
- `rst_n` low mid-run: on that edge return to IDLE with all outputs at reset values; no partial byte is re-offered.
- Address wrap cannot occur because `input_len` ≤ 2^ADDR_W-1.
- `err` updates one cycle after the mismatching newline is accepted.

## Configuration
- `AOC_SEQ_LINE_CHECK_EN` defined:
  - The first nonempty line's width is stored in `ref_w`.
  - Each later newline acceptance with `cur_w`≠`ref_w` sets `err`.
  - The run still completes normally.
- Undefined: width registers are absent and `err` is tied 0. All other behaviour is identical.

## Test plan
- "467..\n", len 6, `sol_ready`=1:
  - Bytes 0x34 0x36 0x37 0x2E 0x2E 0x0A are forwarded in order, one per 3 cycles.
  - `line_count`=1; no pad.
  - `done` rises 2 cycles after the last accept; `result`=`sol_result` at that cycle.
- "..*", len 3:
  - Forwards '.', '.', '*', then padded 0x0A.
  - `line_count`=1.
- "ab\r\n\ncd\n", len 8:
  - Forwards a b \n c d \n (6 bytes); CR and blank line are dropped.
  - `line_count`=2, `err`=0.
- Backpressure: hold `sol_ready`=0 for 5 cycles during SEND of '7'.
  - `sol_valid`=1 and `sol_char`=0x37 stable all 5 cycles.
  - `mem_rd`=0 throughout; the next FETCH follows acceptance.
- "abc\nab\n":
  - With the macro, `err`=1 after the second newline and `done` still reached.
  - Without it, `err`=0.
- Edge cases:
  - len 0: `done` after DRAIN_CYCLES, no `sol_valid`, `line_count`=0.
  - `rst_n`=0 mid-SEND: next cycle all outputs 0; a fresh `start` re-runs the same input with identical results.

Source files
------------

// File: rtl/aoc_input_sequencer.sv
// aoc_input_sequencer: streams a byte-addressed puzzle input into a valid/ready solver core.
// It drops CR bytes and blank lines and appends a missing final newline. After the last
// byte it waits for the solver pipeline to drain, then latches the solver result.
// Optional feature macro: AOC_SEQ_LINE_CHECK_EN enables the ragged-line check on err.
// Ports:
//   clk, rst_n (sync, active-low)
//   start, input_len            run request and byte count
//   mem_rd, mem_addr, mem_data  read port with 1-cycle latency
//   sol_valid, sol_char, sol_ready, sol_result  solver byte stream and running result
//   busy, done, result, line_count, err         run status and outputs
module aoc_input_sequencer #(
  parameter int ADDR_W       = 15,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] input_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              sol_valid,
  output logic [7:0]        sol_char,
  input  logic              sol_ready,
  input  logic [63:0]       sol_result,
  output logic              busy,
  output logic              done,
  output logic [63:0]       result,
  output logic [15:0]       line_count,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, PAD_NL, DRAIN, DONE} state_t;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, len_q, addr_inc;
  logic [7:0] char_q;
  logic [3:0] drain_cnt;
  logic at_start, last_nl, any_fwd;
  logic go, accept, nl, skip;
  assign go        = (state == IDLE || state == DONE) && start;
  assign sol_valid = state == SEND || state == PAD_NL;
  assign sol_char  = state == PAD_NL ? 8'h0A : char_q;
  assign accept    = sol_valid && sol_ready;
  assign nl        = sol_char == 8'h0A;
  assign skip      = mem_data == 8'h0D || (mem_data == 8'h0A && at_start);
  assign addr_inc  = addr + 1'b1;
  assign mem_rd    = state == FETCH;
  assign mem_addr  = addr;
  assign busy      = state != IDLE && state != DONE;
  assign done      = state == DONE;
  // The end check pads a newline only when something was forwarded and the last byte
  // was not already a newline. In SEND the byte being accepted is the last one.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = input_len == '0 ? DRAIN : FETCH;
      FETCH:      state_n = LOAD;
      LOAD:       state_n = !skip ? SEND : addr_inc < len_q ? FETCH :
                            (any_fwd && !last_nl) ? PAD_NL : DRAIN;
      SEND:       if (sol_ready) state_n = addr < len_q ? FETCH : !nl ? PAD_NL : DRAIN;
      PAD_NL:     if (sol_ready) state_n = DRAIN;
      DRAIN:      if (drain_cnt == DRAIN_LAST) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      len_q      <= '0;
      char_q     <= '0;
      drain_cnt  <= '0;
      at_start   <= 1'b0;
      last_nl    <= 1'b0;
      any_fwd    <= 1'b0;
      result     <= '0;
      line_count <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        addr       <= '0;
        len_q      <= input_len;
        drain_cnt  <= '0;
        at_start   <= 1'b1;
        last_nl    <= 1'b0;
        any_fwd    <= 1'b0;
        result     <= '0;
        line_count <= '0;
      end
      if (state == LOAD) begin
        char_q <= mem_data;
        addr   <= addr_inc;
      end
      if (accept) begin
        any_fwd  <= 1'b1;
        last_nl  <= nl;
        at_start <= nl;
        if (nl && line_count != 16'hFFFF) line_count <= line_count + 1'b1;
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
        if (drain_cnt == DRAIN_LAST) result <= sol_result;
      end
    end
  end
`ifdef AOC_SEQ_LINE_CHECK_EN
  logic [ADDR_W-1:0] cur_w, ref_w;
  logic ref_set, err_q;
  // Every accepted newline ends a nonempty line, because blank lines are never
  // forwarded. The first one therefore fixes the reference width.
  always_ff @(posedge clk) begin
    if (!rst_n || go) begin
      cur_w   <= '0;
      ref_w   <= '0;
      ref_set <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      cur_w <= nl ? '0 : cur_w + 1'b1;
      if (nl && !ref_set) begin
        ref_w   <= cur_w;
        ref_set <= 1'b1;
      end
      if (nl && ref_set && cur_w != ref_w) err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_aoc_input_sequencer.sv
// tb_aoc_input_sequencer: directed and random runs against a string-level reference model.
module tb_aoc_input_sequencer;
  localparam int AW = 15;
  localparam int DC = 2;
  typedef byte unsigned bq_t[$];
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sol_ready = 1'b0;
  logic [AW-1:0] input_len = '0;
  logic mem_rd, sol_valid, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_data = 8'h00, sol_char;
  logic [63:0] sol_result = '0, result;
  logic [15:0] line_count;
  int total = 0, bad = 0;
  byte unsigned mem [0:255];

  aoc_input_sequencer #(.ADDR_W(AW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .input_len(input_len),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .sol_valid(sol_valid), .sol_char(sol_char), .sol_ready(sol_ready),
    .sol_result(sol_result), .busy(busy), .done(done), .result(result),
    .line_count(line_count), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr[7:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t to_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_sol_valid"}, sol_valid, 0);
    chk({tag, "_sol_char"}, sol_char, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_line_count"}, line_count, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic run(input bq_t in_q, input int mode, input string tag);
    bq_t exp_q, got;
    int skipped = 0, pad = 0, nls = 0, w = 0, cycles = 0, stalls = 0, since = 0, bp = 0;
    int widths[$];
    bit at = 1'b1, done_seen = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
    logic exp_err = 1'b0;
    logic [7:0] prev_c = 8'h00;
    logic [63:0] last_res = '0;
    foreach (in_q[i]) begin
      mem[i] = in_q[i];
      if (in_q[i] == 8'h0D || (in_q[i] == 8'h0A && at)) skipped++;
      else begin
        exp_q.push_back(in_q[i]);
        at = in_q[i] == 8'h0A;
      end
    end
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1] != 8'h0A) begin
      exp_q.push_back(8'h0A);
      pad = 1;
    end
    foreach (exp_q[i]) begin
      if (exp_q[i] == 8'h0A) begin
        nls++;
        widths.push_back(w);
        w = 0;
      end else w++;
    end
`ifdef AOC_SEQ_LINE_CHECK_EN
    foreach (widths[i]) if (widths[i] != widths[0]) exp_err = 1'b1;
`endif
    @(posedge clk); #1;
    start = 1'b1;
    input_len = AW'(in_q.size());
    @(posedge clk); #1;
    start = 1'b0;
    sol_ready = mode != 1 ? 1'b1 : 1'($urandom_range(0, 1));
    while (cycles < 3000) begin
      @(negedge clk);
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      cycles++;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_rd_vs_valid"}, mem_rd && sol_valid, 0);
      if (prev_v && !prev_r) begin
        chk({tag, "_hold_valid"}, sol_valid, 1);
        chk({tag, "_hold_char"}, sol_char, prev_c);
      end
      if (sol_valid && sol_ready) begin
        got.push_back(sol_char);
        since = 0;
      end else since++;
      if (sol_valid && !sol_ready) stalls++;
      last_res = sol_result;
      prev_v = sol_valid;
      prev_r = sol_ready;
      prev_c = sol_char;
      @(posedge clk); #1;
      sol_result = {$urandom(), $urandom()};
      if (mode == 1) begin
        sol_ready = 1'($urandom_range(0, 1));
        start = busy && ($urandom_range(0, 5) == 0);
        input_len = AW'($urandom_range(0, 200));
      end else if (mode == 2) begin
        sol_ready = !(sol_valid && sol_char == 8'h37 && bp < 5);
        if (!sol_ready) bp++;
      end else sol_ready = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_done_reached"}, done_seen, 1);
    chk({tag, "_cycles"}, cycles, 3 * (exp_q.size() - pad) + 2 * skipped + pad + DC + stalls);
    if (mode == 2) chk({tag, "_stalls"}, stalls, 5);
    if (exp_q.size() > 0) chk({tag, "_drain"}, since, DC);
    chk({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk({tag, "_byte"}, got[i], exp_q[i]);
    chk({tag, "_line_count"}, line_count, nls);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_result"}, result, last_res);
    chk({tag, "_done"}, done, 1);
  endtask

  initial begin
    bq_t q;
    int waits;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(to_q("467..\n"), 0, "t467");
    run(to_q("..*"), 0, "pad");
    run(to_q("ab\015\n\ncd\n"), 0, "crlf");
    run(to_q("467..\n"), 2, "bp");
    run(to_q("abc\nab\n"), 1, "ragged");
    q.delete();
    run(q, 0, "empty");
    run(to_q("\n\015\n"), 0, "allskip");
    q = to_q("467..\n");
    foreach (q[i]) mem[i] = q[i];
    @(posedge clk); #1;
    start = 1'b1;
    input_len = AW'(q.size());
    sol_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    waits = 0;
    while (!sol_valid && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    chk("rst_reach_send", sol_valid, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(q, 0, "rerun");
    for (int r = 0; r < 24; r++) begin
      q.delete();
      if (r % 2 == 0) begin
        int wd = $urandom_range(1, 6), rows = $urandom_range(1, 5);
        for (int y = 0; y < rows; y++) begin
          for (int x = 0; x < wd; x++) q.push_back($urandom_range(0, 1) ? 8'h2E : 8'h23);
          if (y < rows - 1 || $urandom_range(0, 1)) q.push_back(8'h0A);
        end
      end else begin
        int n = $urandom_range(0, 40);
        for (int i = 0; i < n; i++) begin
          int k = $urandom_range(0, 9);
          q.push_back(k < 2 ? 8'h0A : k == 2 ? 8'h0D : k < 6 ? 8'h2E : 8'(48 + k));
        end
      end
      run(q, r % 3 == 0 ? 0 : 1, "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
